// File: rtl/mem_lsu_pkg.sv
// Purpose : shared size codes, error codes and FSM encoding for the load/store unit.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package mem_lsu_pkg;

  // Access size codes carried on i_bhw
  localparam logic [2:0] BHW_B  = 3'b000;
  localparam logic [2:0] BHW_H  = 3'b001;
  localparam logic [2:0] BHW_W  = 3'b011;
  localparam logic [2:0] BHW_BU = 3'b100;
  localparam logic [2:0] BHW_HU = 3'b101;

  // Response error codes carried on o_err
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Classify an access; an illegal size code wins over any alignment problem.
  function automatic logic [1:0] access_err(input logic [2:0] bhw, input logic [1:0] lo);
    case (bhw)
      BHW_B, BHW_BU: access_err = ERR_NONE;
      BHW_H, BHW_HU: access_err = lo[0] ? ERR_MISALIGN : ERR_NONE;
      BHW_W:         access_err = (lo != 2'b00) ? ERR_MISALIGN : ERR_NONE;
      default:       access_err = ERR_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_bram.sv
// Purpose : word-organised storage, 4 lanes per word, per-lane write enable, two async read ports.
// Latency : writes commit on the rising edge; reads are combinational.
// Backpressure: none, always accepts.
// Ports   : clk; we/addr/wdata write + rdata read on the main port; dbg_addr/dbg_data read-only debug port.
module mem_lsu_bram #(
  parameter int NB_ADDR = 9,
  parameter int NB_DATA = 8
) (
  input  logic                 clk,
  input  logic [3:0]           we,
  input  logic [NB_ADDR-3:0]   addr,
  input  logic [4*NB_DATA-1:0] wdata,
  output logic [4*NB_DATA-1:0] rdata,
  input  logic [NB_ADDR-3:0]   dbg_addr,
  output logic [4*NB_DATA-1:0] dbg_data
);

  localparam int DEPTH = 2 ** (NB_ADDR - 2);

  // Contents are deliberately not reset.
  logic [4*NB_DATA-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (we[l]) begin
        mem[addr][l*NB_DATA +: NB_DATA] <= wdata[l*NB_DATA +: NB_DATA];
      end
    end
  end

  assign rdata    = mem[addr];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/mem_lsu.sv
// Purpose : single-outstanding load/store unit over an internal byte-addressed memory.
// Latency : response valid WAIT_CYCLES+1 cycles after acceptance; memory touched on the edge leaving the last access cycle.
// Backpressure: response held stable until i_rsp_ready; o_req_ready only in IDLE.
// Ports   : i_clk/i_reset_n; request i_req_valid/o_req_ready/i_we/i_bhw/i_addr/i_wdata;
//           response o_rsp_valid/i_rsp_ready/o_rdata/o_err; debug i_dunit_addr -> o_dunit_data.
module mem_lsu #(
  parameter int NB_WIDTH    = 32,
  parameter int NB_ADDR     = 9,
  parameter int NB_DATA     = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_we,
  input  logic [2:0]          i_bhw,
  input  logic [NB_WIDTH-1:0] i_addr,
  input  logic [NB_WIDTH-1:0] i_wdata,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [NB_WIDTH-1:0] o_rdata,
  output logic [1:0]          o_err,
  input  logic [NB_WIDTH-1:0] i_dunit_addr,
  output logic [NB_WIDTH-1:0] o_dunit_data
);

  import mem_lsu_pkg::*;

  localparam logic [2:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

  state_t              state, state_nxt;
  logic [2:0]          cnt, cnt_nxt;
  logic                r_we;
  logic [2:0]          r_bhw;
  logic [NB_ADDR-1:0]  r_addr;
  logic [NB_WIDTH-1:0] r_wdata;
  logic [NB_WIDTH-1:0] rdata_q;
  logic [1:0]          err_q;

  logic                accept;
  logic                access;
  logic                a_we;
  logic [2:0]          a_bhw;
  logic [NB_ADDR-1:0]  a_addr;
  logic [NB_WIDTH-1:0] a_wdata;
  logic [1:0]          a_err;
  logic [3:0]          lane_we;
  logic [NB_WIDTH-1:0] lane_wdata;
  logic [NB_WIDTH-1:0] mem_word;
  logic [NB_WIDTH-1:0] shifted;
  logic [NB_DATA-1:0]  byte_v;
  logic [2*NB_DATA-1:0] half_v;
  logic [NB_WIDTH-1:0] load_v;
  logic [NB_WIDTH-1:0] rsp_data;

  assign accept = (state == ST_IDLE) && i_req_valid;

  // With no wait cycles the access happens on the accepting edge itself, so
  // the operands come straight from the inputs; otherwise from the capture regs.
  assign a_we    = (state == ST_IDLE) ? i_we                 : r_we;
  assign a_bhw   = (state == ST_IDLE) ? i_bhw                : r_bhw;
  assign a_addr  = (state == ST_IDLE) ? i_addr[NB_ADDR-1:0]  : r_addr;
  assign a_wdata = (state == ST_IDLE) ? i_wdata              : r_wdata;

  assign access = (WAIT_CYCLES == 0) ? accept : ((state == ST_WAIT) && (cnt == 3'd0));
  assign a_err  = access_err(a_bhw, a_addr[1:0]);

  // Store lane steering: data replicated across lanes, enables pick the target.
  always_comb begin
    lane_we    = 4'b0000;
    lane_wdata = a_wdata;
    case (a_bhw)
      BHW_B, BHW_BU: begin
        lane_we    = 4'b0001 << a_addr[1:0];
        lane_wdata = {4{a_wdata[NB_DATA-1:0]}};
      end
      BHW_H, BHW_HU: begin
        lane_we    = a_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{a_wdata[2*NB_DATA-1:0]}};
      end
      BHW_W:   lane_we = 4'b1111;
      default: lane_we = 4'b0000;
    endcase
    if (!(access && a_we && (a_err == ERR_NONE))) begin
      lane_we = 4'b0000;
    end
  end

  // Load extraction: one right shift by the byte offset serves bytes and
  // (aligned) halfwords alike.
  assign shifted = mem_word >> (a_addr[1:0] * NB_DATA);
  assign byte_v  = shifted[NB_DATA-1:0];
  assign half_v  = shifted[2*NB_DATA-1:0];

  always_comb begin
    load_v = '0;
    case (a_bhw)
      BHW_B:   load_v = {{(NB_WIDTH-NB_DATA){byte_v[NB_DATA-1]}}, byte_v};
      BHW_BU:  load_v = {{(NB_WIDTH-NB_DATA){1'b0}}, byte_v};
      BHW_H:   load_v = {{(NB_WIDTH-2*NB_DATA){half_v[2*NB_DATA-1]}}, half_v};
      BHW_HU:  load_v = {{(NB_WIDTH-2*NB_DATA){1'b0}}, half_v};
      BHW_W:   load_v = mem_word;
      default: load_v = '0;
    endcase
  end

  assign rsp_data = (a_we || (a_err != ERR_NONE)) ? '0 : load_v;

  mem_lsu_bram #(
    .NB_ADDR (NB_ADDR),
    .NB_DATA (NB_DATA)
  ) u_bram (
    .clk      (i_clk),
    .we       (lane_we),
    .addr     (a_addr[NB_ADDR-1:2]),
    .wdata    (lane_wdata),
    .rdata    (mem_word),
    .dbg_addr (i_dunit_addr[NB_ADDR-1:2]),
    .dbg_data (o_dunit_data)
  );

  // FSM state register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= ST_IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = ST_RESP;
          end else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == 3'd0) state_nxt = ST_RESP;
        else             cnt_nxt   = cnt - 3'd1;
      end
      ST_RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request capture and response registers; response only changes on an access
  // edge, which cannot occur in RESP, so it stays stable under backpressure.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_we    <= 1'b0;
      r_bhw   <= 3'b000;
      r_addr  <= '0;
      r_wdata <= '0;
      rdata_q <= '0;
      err_q   <= ERR_NONE;
    end else begin
      if (accept) begin
        r_we    <= i_we;
        r_bhw   <= i_bhw;
        r_addr  <= i_addr[NB_ADDR-1:0];
        r_wdata <= i_wdata;
      end
      if (access) begin
        rdata_q <= rsp_data;
        err_q   <= a_err;
      end
    end
  end

  assign o_rdata = rdata_q;
  assign o_err   = err_q;

  // Address bits outside the memory and the debug byte offset are don't-care.
  logic unused_bits;
  assign unused_bits = ^{i_addr[NB_WIDTH-1:NB_ADDR], i_dunit_addr[NB_WIDTH-1:NB_ADDR],
                         i_dunit_addr[1:0], shifted[NB_WIDTH-1:2*NB_DATA]};

endmodule

// File: tb/tb_mem_lsu.sv
// Purpose : scoreboard bench for mem_lsu, one instance with two wait cycles and one with none.
// Latency : checks response latency of WAIT_CYCLES+1 per request.
// Backpressure: exercises a held response with i_rsp_ready low.
module tb_mem_lsu;

  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b011, BU = 3'b100, HU = 3'b101;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        we;
  logic [2:0]  bhw;
  logic [31:0] addr, wdata, dunit_addr;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        rsp_valid  [2];
  logic        rsp_ready  [2];
  logic [31:0] rdata      [2];
  logic [1:0]  err        [2];
  logic [31:0] dunit_data [2];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    int          acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qpop(input int k);
    if (k == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int WC = (g == 0) ? 2 : 0;
    logic prev = 1'b0;
    exp_t e;

    mem_lsu #(
      .NB_WIDTH    (32),
      .NB_ADDR     (9),
      .NB_DATA     (8),
      .WAIT_CYCLES (WC)
    ) u_dut (
      .i_clk        (clk),
      .i_reset_n    (rst_n),
      .i_req_valid  (req_valid[g]),
      .o_req_ready  (req_ready[g]),
      .i_we         (we),
      .i_bhw        (bhw),
      .i_addr       (addr),
      .i_wdata      (wdata),
      .o_rsp_valid  (rsp_valid[g]),
      .i_rsp_ready  (rsp_ready[g]),
      .o_rdata      (rdata[g]),
      .o_err        (err[g]),
      .i_dunit_addr (dunit_addr),
      .o_dunit_data (dunit_data[g])
    );

    // Monitor: compare on each new response against the oldest expectation.
    always @(negedge clk) begin
      if (!rst_n) begin
        prev = 1'b0;
      end else begin
        if (rsp_valid[g] && !prev) begin
          if (qsize(g) == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL inst%0d unexpected_rsp: got rdata %h err %0d, want no response", g, rdata[g], err[g]);
          end else begin
            e = qpop(g);
            check($sformatf("inst%0d rdata", g), rdata[g], e.rdata);
            check($sformatf("inst%0d err", g), {30'd0, err[g]}, {30'd0, e.err});
            check($sformatf("inst%0d latency", g), 32'(cyc - e.acc), 32'(WC + 1));
          end
        end
        prev = rsp_valid[g];
      end
    end
  end

  task automatic issue(input int k, input logic we_v, input logic [2:0] bhw_v,
                       input logic [31:0] a_v, input logic [31:0] d_v,
                       input logic [31:0] e_rd, input logic [1:0] e_err, output int acc);
    exp_t e;
    int   t;
    t   = 0;
    acc = -1;
    @(negedge clk);
    we = we_v; bhw = bhw_v; addr = a_v; wdata = d_v;
    req_valid[k] = 1'b1;
    while (!req_ready[k] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready[k]) begin
      n_checks++;
      n_errors++;
      $display("FAIL inst%0d accept_timeout: req_ready 0, want 1", k);
      req_valid[k] = 1'b0;
      return;
    end
    e.rdata = e_rd; e.err = e_err; e.acc = cyc;
    acc = cyc;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
  endtask

  task automatic op(input int k, input logic we_v, input logic [2:0] bhw_v,
                    input logic [31:0] a_v, input logic [31:0] d_v,
                    input logic [31:0] e_rd, input logic [1:0] e_err);
    int a;
    issue(k, we_v, bhw_v, a_v, d_v, e_rd, e_err, a);
  endtask

  task automatic wait_idle(input int k);
    int t;
    t = 0;
    while ((qsize(k) != 0 || rsp_valid[k] || !req_ready[k]) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_checks++;
      n_errors++;
      $display("FAIL inst%0d drain_timeout: %0d responses pending, want 0", k, qsize(k));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int a0, a1, a2, a3;
    we = 1'b0; bhw = W; addr = '0; wdata = '0; dunit_addr = 32'h10;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0;
      rsp_ready[k] = 1'b1;
    end
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset req_ready", {31'd0, req_ready[0]}, 32'd1);
    check("reset rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    check("reset rdata", rdata[0], 32'd0);
    check("reset err", {30'd0, err[0]}, 32'd0);
    rst_n = 1'b1;

    // Two wait cycles: basic word, byte and halfword traffic
    op(0, 1, W,  32'h10, 32'hDEADBEEF, 32'h0, 2'b00);
    op(0, 0, W,  32'h10, 32'h0, 32'hDEADBEEF, 2'b00);
    op(0, 1, B,  32'h11, 32'hAAAAAA7F, 32'h0, 2'b00);
    op(0, 0, B,  32'h11, 32'h0, 32'h0000007F, 2'b00);
    op(0, 0, W,  32'h10, 32'h0, 32'hDEAD7FEF, 2'b00);
    op(0, 0, BU, 32'h13, 32'h0, 32'h000000DE, 2'b00);
    op(0, 0, B,  32'h13, 32'h0, 32'hFFFFFFDE, 2'b00);
    // Errors: misaligned store, illegal codes (illegal beats misaligned)
    op(0, 1, H,  32'h13, 32'h00008001, 32'h0, 2'b01);
    op(0, 0, W,  32'h10, 32'h0, 32'hDEAD7FEF, 2'b00);
    op(0, 0, 3'b110, 32'h10, 32'h0, 32'h0, 2'b10);
    op(0, 1, 3'b111, 32'h13, 32'hFFFFFFFF, 32'h0, 2'b10);
    op(0, 0, W,  32'h12, 32'h0, 32'h0, 2'b01);
    op(0, 0, HU, 32'h11, 32'h0, 32'h0, 2'b01);
    op(0, 0, W,  32'h10, 32'h0, 32'hDEAD7FEF, 2'b00);
    // Halfwords, extension and address wrap
    op(0, 1, H,  32'h12, 32'h00008001, 32'h0, 2'b00);
    op(0, 0, H,  32'h12, 32'h0, 32'hFFFF8001, 2'b00);
    op(0, 0, HU, 32'h12, 32'h0, 32'h00008001, 2'b00);
    op(0, 0, H,  32'h10, 32'h0, 32'h00007FEF, 2'b00);
    op(0, 0, B,  32'h10, 32'h0, 32'hFFFFFFEF, 2'b00);
    op(0, 0, W,  32'h210, 32'h0, 32'h80017FEF, 2'b00);
    wait_idle(0);
    check("inst0 dunit", dunit_data[0], 32'h80017FEF);

    // Backpressure: held response, new request ignored
    rsp_ready[0] = 1'b0;
    op(0, 0, W, 32'h10, 32'h0, 32'h80017FEF, 2'b00);
    t = 0;
    while (!rsp_valid[0] && t < 20) begin
      @(negedge clk);
      t++;
    end
    we = 1'b1; bhw = W; addr = 32'h10; wdata = 32'hFFFFFFFF;
    req_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp rsp_valid", {31'd0, rsp_valid[0]}, 32'd1);
      check("bp rdata", rdata[0], 32'h80017FEF);
      check("bp err", {30'd0, err[0]}, 32'd0);
      check("bp req_ready", {31'd0, req_ready[0]}, 32'd0);
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    wait_idle(0);
    op(0, 0, W, 32'h10, 32'h0, 32'h80017FEF, 2'b00);

    // Reset during WAIT aborts the store
    op(0, 1, W, 32'h20, 32'hCAFEF00D, 32'h0, 2'b00);
    op(0, 0, W, 32'h20, 32'h0, 32'hCAFEF00D, 2'b00);
    wait_idle(0);
    @(negedge clk);
    we = 1'b1; bhw = W; addr = 32'h20; wdata = 32'h12345678;
    req_valid[0] = 1'b1;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    check("rst rdata", rdata[0], 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst req_ready", {31'd0, req_ready[0]}, 32'd1);
    op(0, 0, W, 32'h20, 32'h0, 32'hCAFEF00D, 2'b00);
    wait_idle(0);

    // No wait cycles: back-to-back, debug port follows stores
    issue(1, 1, W, 32'h10, 32'h11223344, 32'h0, 2'b00, a0);
    check("inst1 dunit sw", dunit_data[1], 32'h11223344);
    issue(1, 1, H, 32'h12, 32'h0000BEEF, 32'h0, 2'b00, a1);
    check("inst1 dunit sh", dunit_data[1], 32'hBEEF3344);
    issue(1, 1, B, 32'h10, 32'h00000055, 32'h0, 2'b00, a2);
    check("inst1 dunit sb", dunit_data[1], 32'hBEEF3355);
    issue(1, 0, W, 32'h10, 32'h0, 32'hBEEF3355, 2'b00, a3);
    check("inst1 spacing 1", 32'(a1 - a0), 32'd2);
    check("inst1 spacing 2", 32'(a2 - a1), 32'd2);
    check("inst1 spacing 3", 32'(a3 - a2), 32'd2);
    wait_idle(1);
    wait_idle(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
